arm_decode_issue: RTL and testbench

- Decode/issue stage for the pipelined ARM core.
- Accepts raw 32-bit instruction words from fetch and splits them into fields: cond[31:28], op[27:26], I[25], cmd[24:21], S[20], rn[19:16], rd[15:12], src2[11:0].
- Evaluates the condition against an internal NZCV copy and stalls on register and flag hazards using a scoreboard. Software therefore no longer needs 4 NOPs between dependent instructions.
- Sits between the fetch register and the execute stage. Write-back and flag-update feedback comes from the later stages.

---
 rtl/arm_decode_issue.sv | 216 +++++++++++++++++++++
 tb/tb_arm_decode_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_decode_issue.sv
// Decode/issue stage: splits the fetched ARM word into fields, evaluates the
// condition against a local NZCV copy, and uses a register/flag scoreboard to
// hold back dependent instructions until write-back or flag update lands.
// Optional macro ARM_DECODE_PERF_EN adds issue_count/stall_count outputs.
module arm_decode_issue #(
  parameter int          NREGS   = 16,
  parameter logic [3:0]  AL_COND = 4'b1110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] PC,
  input  logic [31:0] Instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [1:0]  out_op,
  output logic [3:0]  out_cmd,
  output logic        out_imm_en,
  output logic [3:0]  out_rn,
  output logic [3:0]  out_rd,
  output logic [3:0]  out_rm,
  output logic [31:0] out_imm,
  output logic        out_reg_we,
  output logic        out_mem_we,
  output logic        out_flags_we,
  output logic        out_branch,
  input  logic        wb_we,
  input  logic [3:0]  wb_rd,
  input  logic        flags_we,
  input  logic [3:0]  flags_in,
  output logic        hazard
`ifdef ARM_DECODE_PERF_EN
  ,
  output logic [31:0] issue_count,
  output logic [31:0] stall_count
`endif
);

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        imm_en;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_we;
    logic        flags_we;
    logic        branch;
  } dec_t;

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [3:0] R15     = 4'hF;

  // Field split
  logic [3:0]  cond;
  logic [1:0]  op;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;
  logic [3:0]  rn, rd;
  logic [11:0] src2;

  assign cond  = Instruction[31:28];
  assign op    = Instruction[27:26];
  assign i_bit = Instruction[25];
  assign cmd   = Instruction[24:21];
  assign s_bit = Instruction[20];
  assign rn    = Instruction[19:16];
  assign rd    = Instruction[15:12];
  assign src2  = Instruction[11:0];

  // State
  dec_t             out_q, dec_d;
  logic             out_valid_q;
  logic [NREGS-1:0] pend_q, pend_d;
  logic             flags_pend_q, flags_pend_d;
  logic [3:0]       nzcv_q, nzcv_d;

  logic cond_pass, reg_blk, issue;
  logic n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = nzcv_q;

  // Condition check against the flags as they stand at issue time
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f & !z_f;
      4'b1001: cond_pass = !c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Hazard detection; clears from write-back are not bypassed, so only the
  // registered scoreboard is consulted
  always_comb begin
    reg_blk = 1'b0;
    if (op != OP_BR && rn != R15 && pend_q[rn])                 reg_blk = 1'b1;
    if (op != OP_BR && !i_bit && src2[3:0] != R15 && pend_q[src2[3:0]]) reg_blk = 1'b1;
    if (op == OP_MEM && !s_bit && rd != R15 && pend_q[rd])      reg_blk = 1'b1;
  end

  assign hazard   = in_valid & (reg_blk | ((cond != AL_COND) & flags_pend_q));
  assign in_ready = (!out_valid_q | out_ready) & !hazard;
  assign issue    = in_valid & in_ready;

  // Decode into the bundle that the output register captures; enables are
  // squashed on condition failure but the instruction still flows
  always_comb begin
    dec_d          = '0;
    dec_d.pc       = PC;
    dec_d.op       = op;
    dec_d.cmd      = cmd;
    dec_d.imm_en   = i_bit;
    dec_d.rn       = rn;
    dec_d.rd       = rd;
    dec_d.rm       = src2[3:0];
    dec_d.imm      = (op == OP_BR) ? {{6{Instruction[23]}}, Instruction[23:0], 2'b00}
                                   : {20'd0, src2};
    dec_d.reg_we   = cond_pass & (((op == OP_DATA) & (cmd[3:2] != 2'b10)) |
                                  ((op == OP_MEM) & s_bit));
    dec_d.mem_we   = cond_pass & (op == OP_MEM) & !s_bit;
    dec_d.flags_we = cond_pass & (op == OP_DATA) & s_bit;
    dec_d.branch   = cond_pass & (op == OP_BR);
  end

  // Scoreboard next state: retire first, then issue sets so set wins a tie
  always_comb begin
    pend_d = pend_q;
    if (wb_we) pend_d[wb_rd] = 1'b0;
    if (issue && dec_d.reg_we && rd != R15) pend_d[rd] = 1'b1;
    flags_pend_d = flags_pend_q;
    if (flags_we) flags_pend_d = 1'b0;
    if (issue && dec_d.flags_we) flags_pend_d = 1'b1;
    nzcv_d = flags_we ? flags_in : nzcv_q;
  end

  // Output register: load on issue, drop valid when drained with nothing new
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (issue) begin
      out_q       <= dec_d;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Scoreboard and flag copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      flags_pend_q <= 1'b0;
      nzcv_q       <= 4'b0000;
    end else begin
      pend_q       <= pend_d;
      flags_pend_q <= flags_pend_d;
      nzcv_q       <= nzcv_d;
    end
  end

`ifdef ARM_DECODE_PERF_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;

  // Free-running wrap-around counters for issues and hazard stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue)              issue_cnt_q <= issue_cnt_q + 32'd1;
      if (in_valid && hazard) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_op       = out_q.op;
  assign out_cmd      = out_q.cmd;
  assign out_imm_en   = out_q.imm_en;
  assign out_rn       = out_q.rn;
  assign out_rd       = out_q.rd;
  assign out_rm       = out_q.rm;
  assign out_imm      = out_q.imm;
  assign out_reg_we   = out_q.reg_we;
  assign out_mem_we   = out_q.mem_we;
  assign out_flags_we = out_q.flags_we;
  assign out_branch   = out_q.branch;

endmodule

// File: tb/tb_arm_decode_issue.sv
// Directed bench for arm_decode_issue: a decode table from a clean
// scoreboard, then hand-written stall, back-pressure and reset sequences.
module tb_arm_decode_issue;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] PC, Instruction, out_pc, out_imm;
  logic [1:0]  out_op;
  logic [3:0]  out_cmd, out_rn, out_rd, out_rm, wb_rd, flags_in;
  logic        out_imm_en, out_reg_we, out_mem_we, out_flags_we, out_branch;
  logic        wb_we, flags_we, hazard;
`ifdef ARM_DECODE_PERF_EN
  logic [31:0] issue_count, stall_count;
`endif

  arm_decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .PC(PC), .Instruction(Instruction), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_cmd(out_cmd), .out_imm_en(out_imm_en),
    .out_rn(out_rn), .out_rd(out_rd), .out_rm(out_rm), .out_imm(out_imm),
    .out_reg_we(out_reg_we), .out_mem_we(out_mem_we), .out_flags_we(out_flags_we),
    .out_branch(out_branch), .wb_we(wb_we), .wb_rd(wb_rd), .flags_we(flags_we),
    .flags_in(flags_in), .hazard(hazard)
`ifdef ARM_DECODE_PERF_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  nzcv;
    logic [31:0] instr;
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        imm_en;
    logic [3:0]  rn, rd, rm;
    logic [31:0] imm;
    logic        reg_we, mem_we, flags_we, branch;
    logic [15:0] pend;
    logic        fpend;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1; wb_we = 1'b0; wb_rd = 4'd0;
    flags_we = 1'b0; flags_in = 4'd0; Instruction = 32'd0; PC = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    string s;
    do_reset();
    flags_we = 1'b1; flags_in = vecs[i].nzcv;
    tick();
    flags_we = 1'b0;
    in_valid = 1'b1; Instruction = vecs[i].instr; PC = 32'h100 + 32'(i) * 4;
    #1;
    s = $sformatf("v%0d", i);
    chk({s, ".hazard"}, 32'(hazard), 32'd0);
    tick();
    in_valid = 1'b0;
    chk({s, ".valid"}, 32'(out_valid), 32'd1);
    chk({s, ".pc"}, out_pc, 32'h100 + 32'(i) * 4);
    chk({s, ".op"}, 32'(out_op), 32'(vecs[i].op));
    chk({s, ".cmd"}, 32'(out_cmd), 32'(vecs[i].cmd));
    chk({s, ".imm_en"}, 32'(out_imm_en), 32'(vecs[i].imm_en));
    chk({s, ".rn"}, 32'(out_rn), 32'(vecs[i].rn));
    chk({s, ".rd"}, 32'(out_rd), 32'(vecs[i].rd));
    chk({s, ".rm"}, 32'(out_rm), 32'(vecs[i].rm));
    chk({s, ".imm"}, out_imm, vecs[i].imm);
    chk({s, ".we"}, {28'd0, out_reg_we, out_mem_we, out_flags_we, out_branch},
        {28'd0, vecs[i].reg_we, vecs[i].mem_we, vecs[i].flags_we, vecs[i].branch});
    chk({s, ".pend"}, 32'(dut.pend_q), 32'(vecs[i].pend));
    chk({s, ".fpend"}, 32'(dut.flags_pend_q), 32'(vecs[i].fpend));
  endtask

  initial begin
    //          nzcv     instr         op     cmd   I     rn    rd    rm    imm           rw    mw    fw    br    pend      fp
    vecs[0]  = '{4'b0000, 32'hE2900007, 2'b00, 4'h4, 1'b1, 4'h0, 4'h0, 4'h7, 32'h00000007, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1}; // ADDS R0,R0,#7
    vecs[1]  = '{4'b0000, 32'hEA000004, 2'b10, 4'h0, 1'b1, 4'h0, 4'h0, 4'h4, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0}; // B +0x10
    vecs[2]  = '{4'b0000, 32'hEAFFFFFE, 2'b10, 4'h7, 1'b1, 4'hF, 4'hF, 4'hE, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0}; // B backwards
    vecs[3]  = '{4'b0000, 32'hE5830000, 2'b01, 4'hC, 1'b0, 4'h3, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}; // STR R0,[R3]
    vecs[4]  = '{4'b0000, 32'hE5954000, 2'b01, 4'hC, 1'b0, 4'h5, 4'h4, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0}; // LDR R4,[R5]
    vecs[5]  = '{4'b0000, 32'hE3550000, 2'b00, 4'hA, 1'b1, 4'h5, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1}; // CMP R5,#0
    vecs[6]  = '{4'b0000, 32'h00000000, 2'b00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}; // NOP, Z=0
    vecs[7]  = '{4'b0100, 32'h00000000, 2'b00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0}; // ANDEQ, Z=1
    vecs[8]  = '{4'b0000, 32'hE281F000, 2'b00, 4'h4, 1'b1, 4'h1, 4'hF, 4'h0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}; // ADD R15: untracked
    vecs[9]  = '{4'b1001, 32'hC2822001, 2'b00, 4'h4, 1'b1, 4'h2, 4'h2, 4'h1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0}; // GT pass
    vecs[10] = '{4'b1001, 32'hB2822001, 2'b00, 4'h4, 1'b1, 4'h2, 4'h2, 4'h1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}; // LT fail
    vecs[11] = '{4'b0000, 32'hF2822001, 2'b00, 4'h4, 1'b1, 4'h2, 4'h2, 4'h1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0}; // never
    vecs[12] = '{4'b0010, 32'h82822001, 2'b00, 4'h4, 1'b1, 4'h2, 4'h2, 4'h1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0}; // HI pass
    vecs[13] = '{4'b0110, 32'h92822001, 2'b00, 4'h4, 1'b1, 4'h2, 4'h2, 4'h1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b0}; // LS pass

    idle();
    reset = 1'b1;
    tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.pc", out_pc, 32'd0);
    chk("rst.imm", out_imm, 32'd0);
    chk("rst.pend", 32'(dut.pend_q), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Register dependency then conditional flag waits
    do_reset();
    in_valid = 1'b1; Instruction = 32'hE2900007;
    tick();
    chk("A.add.valid", 32'(out_valid), 32'd1);
    chk("A.add.imm", out_imm, 32'd7);
    Instruction = 32'hE2801002;                      // ADD R1,R0,#2
    #1;
    chk("A.dep.hazard", 32'(hazard), 32'd1);
    chk("A.dep.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("A.dep.hazard2", 32'(hazard), 32'd1);
    chk("A.dep.drained", 32'(out_valid), 32'd0);
    wb_we = 1'b1; wb_rd = 4'd0;
    #1;
    chk("A.wb.nobypass", 32'(hazard), 32'd1);
    tick();
    wb_we = 1'b0;
    #1;
    chk("A.wb.hazard_gone", 32'(hazard), 32'd0);
    chk("A.wb.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("A.dep.rd", 32'(out_rd), 32'd1);
    chk("A.dep.imm", out_imm, 32'd2);
    chk("A.dep.pend", 32'(dut.pend_q), 32'h0002);

    Instruction = 32'h02822001;                      // ADDEQ R2,R2,#1
    #1;
    chk("A.eq.hazard", 32'(hazard), 32'd1);
    tick();
    flags_we = 1'b1; flags_in = 4'b0100;
    #1;
    chk("A.eq.hazard_during_fw", 32'(hazard), 32'd1);
    tick();
    flags_we = 1'b0;
    #1;
    chk("A.eq.hazard_gone", 32'(hazard), 32'd0);
    tick();
    chk("A.eq.rd", 32'(out_rd), 32'd2);
    chk("A.eq.reg_we", 32'(out_reg_we), 32'd1);

    Instruction = 32'hE3550000;                      // CMP R5,#0 alongside a flag update
    flags_we = 1'b1; flags_in = 4'b0000;
    tick();
    flags_we = 1'b0;
    chk("A.cmp.flags_we", 32'(out_flags_we), 32'd1);
    chk("A.cmp.fpend_set_wins", 32'(dut.flags_pend_q), 32'd1);

    Instruction = 32'h02866001;                      // ADDEQ R6,R6,#1
    #1;
    chk("A.eq0.hazard", 32'(hazard), 32'd1);
    tick();
    flags_we = 1'b1; flags_in = 4'b0000;
    tick();
    flags_we = 1'b0;
    tick();
    chk("A.eq0.rd", 32'(out_rd), 32'd6);
    chk("A.eq0.enables", {28'd0, out_reg_we, out_mem_we, out_flags_we, out_branch}, 32'd0);
    chk("A.eq0.pend", 32'(dut.pend_q), 32'h0006);

    Instruction = 32'hE2843005;                      // ADD R3 while R3 retires
    wb_we = 1'b1; wb_rd = 4'd3;
    tick();
    wb_we = 1'b0; in_valid = 1'b0;
    chk("A.setwins.pend", 32'(dut.pend_q), 32'h000E);

    // Back-pressure
    do_reset();
    in_valid = 1'b1; Instruction = 32'hE2821003; PC = 32'h200;
    tick();
    out_ready = 1'b0; Instruction = 32'hE2843005; PC = 32'h204;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("B.hold.in_ready", 32'(in_ready), 32'd0);
      chk("B.hold.rd", 32'(out_rd), 32'd1);
      chk("B.hold.imm", out_imm, 32'd3);
      chk("B.hold.pc", out_pc, 32'h200);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("B.release.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("B.next.rd", 32'(out_rd), 32'd3);
    chk("B.next.pc", out_pc, 32'h204);

    // Store reads rd as data
    do_reset();
    in_valid = 1'b1; Instruction = 32'hE2900007;
    tick();
    Instruction = 32'hE5830000;
    #1;
    chk("C.str.hazard", 32'(hazard), 32'd1);
    tick();
    chk("C.str.hazard2", 32'(hazard), 32'd1);
    wb_we = 1'b1; wb_rd = 4'd0;
    tick();
    wb_we = 1'b0;
    #1;
    chk("C.str.hazard_gone", 32'(hazard), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("C.str.mem_we", 32'(out_mem_we), 32'd1);
    chk("C.str.rn", 32'(out_rn), 32'd3);
    chk("C.str.pend", 32'(dut.pend_q), 32'd0);

    // Async reset in the middle of a stall
    do_reset();
    flags_we = 1'b1; flags_in = 4'b1111;
    tick();
    flags_we = 1'b0;
    in_valid = 1'b1; Instruction = 32'hE2900007;
    tick();
    out_ready = 1'b0; Instruction = 32'hE2801002;
    tick(); tick();
    chk("D.pre.valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("D.rst.valid", 32'(out_valid), 32'd0);
    chk("D.rst.pend", 32'(dut.pend_q), 32'd0);
    chk("D.rst.fpend", 32'(dut.flags_pend_q), 32'd0);
    chk("D.rst.nzcv", 32'(dut.nzcv_q), 32'd0);
    chk("D.rst.rd", 32'(out_imm), 32'd0);
    idle();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
